// File: rtl/fetch_icache_pkg.sv
// Shared types, widths and PC slicing helpers for the fetch icache responder.
package fetch_icache_pkg;

    localparam int unsigned DEFAULT_NUM_LINES = 64;
    localparam int unsigned WF_ID_WIDTH       = 6;
    localparam int unsigned PC_WIDTH          = 32;
    localparam int unsigned INSTR_WIDTH       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StMiss,
        StResp
    } fetch_state_e;

    // Line index of a byte PC; the caller truncates to idx_bits.
    function automatic logic [PC_WIDTH-1:0] pc_index(input logic [PC_WIDTH-1:0] pc,
                                                     input int unsigned idx_bits);
        logic [PC_WIDTH-1:0] mask;
        mask = (PC_WIDTH'(1) << idx_bits) - PC_WIDTH'(1);
        return (pc >> 2) & mask;
    endfunction

    // Tag of a byte PC; the caller truncates to PC_WIDTH - idx_bits - 2.
    function automatic logic [PC_WIDTH-1:0] pc_tag(input logic [PC_WIDTH-1:0] pc,
                                                   input int unsigned idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/fetch_icache_responder_if.sv
// Fetch request/response, instruction-memory and maintenance signals of the responder.
interface fetch_icache_responder_if;
    import fetch_icache_pkg::*;

    logic                   fetch_valid;
    logic [WF_ID_WIDTH-1:0] fetch_wfid;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   icache_ready;
    logic                   icache_ack;
    logic [WF_ID_WIDTH-1:0] icache_wfid;
    logic [PC_WIDTH-1:0]    icache_pc;
    logic [INSTR_WIDTH-1:0] icache_instr;
    logic                   mem_rd_en;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_rd_data;
    logic                   invalidate;
    logic [15:0]            miss_count;

    // Arbiter plus memory environment side.
    modport master (
        output fetch_valid, fetch_wfid, fetch_pc, mem_ack, mem_rd_data, invalidate,
        input  icache_ready, icache_ack, icache_wfid, icache_pc, icache_instr,
        input  mem_rd_en, mem_addr, miss_count
    );

    // Responder side.
    modport slave (
        input  fetch_valid, fetch_wfid, fetch_pc, mem_ack, mem_rd_data, invalidate,
        output icache_ready, icache_ack, icache_wfid, icache_pc, icache_instr,
        output mem_rd_en, mem_addr, miss_count
    );

endinterface

// File: rtl/icache_tag_data_array.sv
// Direct-mapped valid/tag/data storage: combinational read, synchronous write,
// bulk invalidate that overrides the valid bit of a same-cycle write.
module icache_tag_data_array #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_W     = 24,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_all
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES];

    // Valid bits: reset and invalidate win over a fill.
    always_ff @(posedge clk) begin
        if (rst || inv_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data payload; only meaningful when the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/fetch_icache_responder.sv
// Fetch responder: accepts one request at a time, looks it up in a direct-mapped
// icache, refills from instruction memory on a miss and returns a one-cycle ack.
module fetch_icache_responder
    import fetch_icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = DEFAULT_NUM_LINES
) (
    input logic                     clk,
    input logic                     rst,
    fetch_icache_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = PC_WIDTH - IDX_W - 2;

    fetch_state_e           state_q, state_d;
    logic [WF_ID_WIDTH-1:0] req_wfid_q, req_wfid_d;
    logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic                   ack_q, ack_d;
    logic [WF_ID_WIDTH-1:0] resp_wfid_q, resp_wfid_d;
    logic [PC_WIDTH-1:0]    resp_pc_q, resp_pc_d;
    logic [INSTR_WIDTH-1:0] resp_instr_q, resp_instr_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [PC_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [15:0]            miss_count_q, miss_count_d;

    logic [IDX_W-1:0]       req_index;
    logic [TAG_W-1:0]       req_tag;
    logic                   line_valid;
    logic [TAG_W-1:0]       line_tag;
    logic [INSTR_WIDTH-1:0] line_data;
    logic                   hit;
    logic                   fill_en;

    assign req_index = IDX_W'(pc_index(req_pc_q, IDX_W));
    assign req_tag   = TAG_W'(pc_tag(req_pc_q, IDX_W));
    assign hit       = line_valid && (line_tag == req_tag);
    assign fill_en   = (state_q == StMiss) && bus.mem_ack;

    icache_tag_data_array #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .DATA_W   (INSTR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_index(req_index),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .wr_en   (fill_en),
        .wr_index(req_index),
        .wr_tag  (req_tag),
        .wr_data (bus.mem_rd_data),
        .inv_all (bus.invalidate)
    );

    // Next-state and registered-output values; ack is set on entry to StResp.
    always_comb begin
        state_d      = state_q;
        req_wfid_d   = req_wfid_q;
        req_pc_d     = req_pc_q;
        ack_d        = 1'b0;
        resp_wfid_d  = resp_wfid_q;
        resp_pc_d    = resp_pc_q;
        resp_instr_d = resp_instr_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_addr_d   = mem_addr_q;
        miss_count_d = miss_count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.fetch_valid) begin
                    req_wfid_d = bus.fetch_wfid;
                    req_pc_d   = bus.fetch_pc;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    resp_wfid_d  = req_wfid_q;
                    resp_pc_d    = req_pc_q;
                    resp_instr_d = line_data;
                    ack_d        = 1'b1;
                    state_d      = StResp;
                end else begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {req_pc_q[PC_WIDTH-1:2], 2'b00};
                    state_d     = StMiss;
                end
            end
            StMiss: begin
                if (bus.mem_ack) begin
                    resp_wfid_d  = req_wfid_q;
                    resp_pc_d    = req_pc_q;
                    resp_instr_d = bus.mem_rd_data;
                    mem_rd_en_d  = 1'b0;
                    ack_d        = 1'b1;
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_wfid_q   <= '0;
            req_pc_q     <= '0;
            ack_q        <= 1'b0;
            resp_wfid_q  <= '0;
            resp_pc_q    <= '0;
            resp_instr_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_wfid_q   <= req_wfid_d;
            req_pc_q     <= req_pc_d;
            ack_q        <= ack_d;
            resp_wfid_q  <= resp_wfid_d;
            resp_pc_q    <= resp_pc_d;
            resp_instr_q <= resp_instr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.icache_ready = (state_q == StIdle);
    assign bus.icache_ack   = ack_q;
    assign bus.icache_wfid  = resp_wfid_q;
    assign bus.icache_pc    = resp_pc_q;
    assign bus.icache_instr = resp_instr_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.miss_count   = miss_count_q;

endmodule

// File: tb/tb_fetch_icache_responder.sv
// Bench for fetch_icache_responder: scripted fetches against a reference cache
// model; expected responses are queued at request time and popped on each ack.
module tb_fetch_icache_responder;
    import fetch_icache_pkg::*;

    typedef struct packed {
        logic [WF_ID_WIDTH-1:0] wfid;
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } resp_t;

    logic clk = 1'b0;
    logic rst;

    fetch_icache_responder_if bus ();

    fetch_icache_responder #(
        .NUM_LINES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];
    logic        model_valid [64];
    logic [23:0] model_tag   [64];
    int          model_miss;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.icache_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_ack", 32'(bus.icache_ack), 32'd0);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check_val("resp_wfid", 32'(bus.icache_wfid), 32'(r.wfid));
                check_val("resp_pc", bus.icache_pc, r.pc);
                check_val("resp_instr", bus.icache_instr, r.instr);
            end
        end
    end

    // One complete fetch; delay = cycles from mem_rd_en rising to mem_ack.
    task automatic do_fetch(input logic [5:0] wfid, input logic [31:0] pc, input int delay,
                            input bit inv_req, input bit inv_fill, input bit poke);
        logic [5:0]  idx;
        logic [23:0] tg;
        logic [31:0] waddr;
        bit          hit;
        resp_t       r;
        idx   = pc[7:2];
        tg    = pc[31:8];
        waddr = {pc[31:2], 2'b00};
        if (inv_req) model_clear();
        hit = model_valid[idx] && (model_tag[idx] == tg);

        @(posedge clk); #1;
        check_val("ready_before_req", 32'(bus.icache_ready), 32'd1);
        bus.fetch_valid = 1'b1;
        bus.fetch_wfid  = wfid;
        bus.fetch_pc    = pc;
        bus.invalidate  = inv_req;
        r.wfid  = wfid;
        r.pc    = pc;
        r.instr = mem_word(waddr);
        exp_q.push_back(r);

        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        bus.invalidate  = 1'b0;
        check_val("lookup_no_ack", 32'(bus.icache_ack), 32'd0);
        check_val("lookup_no_rd", 32'(bus.mem_rd_en), 32'd0);
        check_val("lookup_busy", 32'(bus.icache_ready), 32'd0);

        @(posedge clk); #1;
        if (hit) begin
            check_val("hit_ack", 32'(bus.icache_ack), 32'd1);
            check_val("hit_no_rd", 32'(bus.mem_rd_en), 32'd0);
        end else begin
            check_val("miss_rd_en", 32'(bus.mem_rd_en), 32'd1);
            check_val("miss_addr", bus.mem_addr, waddr);
            check_val("miss_no_ack", 32'(bus.icache_ack), 32'd0);
            if (poke) begin
                bus.fetch_valid = 1'b1;
                bus.fetch_wfid  = 6'd7;
                bus.fetch_pc    = 32'h300;
            end
            for (int k = 1; k < delay; k++) begin
                @(posedge clk); #1;
                bus.fetch_valid = 1'b0;
                check_val("miss_rd_held", 32'(bus.mem_rd_en), 32'd1);
                check_val("miss_wait_no_ack", 32'(bus.icache_ack), 32'd0);
            end
            bus.fetch_valid = 1'b0;
            bus.mem_ack     = 1'b1;
            bus.mem_rd_data = mem_word(waddr);
            bus.invalidate  = inv_fill;
            @(posedge clk); #1;
            bus.mem_ack     = 1'b0;
            bus.mem_rd_data = '0;
            bus.invalidate  = 1'b0;
            check_val("fill_ack", 32'(bus.icache_ack), 32'd1);
            check_val("fill_rd_drop", 32'(bus.mem_rd_en), 32'd0);
            if (inv_fill) model_clear();
            model_tag[idx]   = tg;
            model_valid[idx] = !inv_fill;
            model_miss++;
        end
        check_val("miss_count", 32'(bus.miss_count), 32'(model_miss));

        @(posedge clk); #1;
        check_val("ack_one_cycle", 32'(bus.icache_ack), 32'd0);
        check_val("ready_after_resp", 32'(bus.icache_ready), 32'd1);
    endtask

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_wfid  = '0;
        bus.fetch_pc    = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = '0;
        bus.invalidate  = 1'b0;
        model_clear();
        model_miss = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_ready", 32'(bus.icache_ready), 32'd1);
        check_val("rst_ack", 32'(bus.icache_ack), 32'd0);
        check_val("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'd0);
        check_val("rst_miss_count", 32'(bus.miss_count), 32'd0);
        check_val("rst_wfid", 32'(bus.icache_wfid), 32'd0);
        check_val("rst_pc", bus.icache_pc, 32'd0);
        check_val("rst_instr", bus.icache_instr, 32'd0);

        do_fetch(6'd5,  32'h100, 3, 1'b0, 1'b0, 1'b0);  // cold miss
        do_fetch(6'd9,  32'h102, 0, 1'b0, 1'b0, 1'b0);  // hit, low PC bits ignored
        do_fetch(6'd2,  32'h200, 3, 1'b0, 1'b0, 1'b1);  // conflict miss, busy request dropped
        do_fetch(6'd3,  32'h100, 1, 1'b0, 1'b0, 1'b0);  // evicted line misses, ack in first MISS cycle
        do_fetch(6'd4,  32'h400, 2, 1'b0, 1'b1, 1'b0);  // invalidate on fill
        do_fetch(6'd6,  32'h400, 1, 1'b0, 1'b0, 1'b0);  // repeat misses
        do_fetch(6'd10, 32'h104, 2, 1'b0, 1'b0, 1'b0);  // miss on index 1
        do_fetch(6'd11, 32'h107, 0, 1'b0, 1'b0, 1'b0);  // hit
        do_fetch(6'd12, 32'h104, 2, 1'b1, 1'b0, 1'b0);  // invalidate with request -> miss

        // Reset while a miss is outstanding.
        @(posedge clk); #1;
        bus.fetch_valid = 1'b1;
        bus.fetch_wfid  = 6'd13;
        bus.fetch_pc    = 32'h500;
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        @(posedge clk); #1;
        check_val("pre_rst_rd_en", 32'(bus.mem_rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_val("midrst_ready", 32'(bus.icache_ready), 32'd1);
        check_val("midrst_miss_count", 32'(bus.miss_count), 32'd0);
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        check_val("late_ack_no_resp", 32'(bus.icache_ack), 32'd0);
        check_val("late_ack_ready", 32'(bus.icache_ready), 32'd1);
        check_val("late_ack_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_val("late_ack_count", 32'(bus.miss_count), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_val("post_rst_no_ack", 32'(bus.icache_ack), 32'd0);
        end
        model_clear();
        model_miss = 0;

        do_fetch(6'd14, 32'h100, 2, 1'b0, 1'b0, 1'b0);  // valid bits cleared by reset

        repeat (2) @(posedge clk);
        #1 check_val("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
